// File: rtl/vs_spi_pkg.sv
// Shared constants for the VS1003 serial-bus arbiter: FSM encoding, word sizes
// and the SCI opcodes/registers used by the command requesters.
package vs_spi_pkg;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SHIFT  = 2'd1;
  localparam logic [1:0] S_FINISH = 2'd2;
  localparam logic [1:0] S_GAP    = 2'd3;

  localparam int CMD_BITS  = 32;
  localparam int DATA_BITS = 16;

  localparam logic [7:0]  SCI_WRITE       = 8'h02;
  localparam logic [7:0]  REG_MODE        = 8'h00;
  localparam logic [7:0]  REG_VOL         = 8'h0B;
  localparam logic [15:0] MODE_SOFT_RESET = 16'h0804;

  // Assembles an SCI word in wire order: opcode, register address, data.
  function automatic logic [31:0] sci_word(input logic [7:0] op,
                                           input logic [7:0] addr,
                                           input logic [15:0] data);
    return {op, addr, data};
  endfunction

endpackage

// File: rtl/spi_tick_gen.sv
// Free-running divider; tick marks the last I_CLK cycle of each SCLK half-period.
module spi_tick_gen #(
  parameter int CLK_DIV = 50
) (
  input  logic I_CLK,
  input  logic RST,
  output logic tick
);

  localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] TC = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge I_CLK) begin
    if (!RST)          cnt <= '0;
    else if (cnt == TC) cnt <= '0;
    else               cnt <= cnt + 1'b1;
  end

  assign tick = (cnt == TC);

endmodule

// File: rtl/vs_spi_arbiter.sv
// Owns the VS1003 serial bus and arbitrates SCI command words against SDI data
// words, with a starvation bound that eventually forces a data grant.
//
// state  | meaning
// IDLE   | selects high, waiting for DREQ and a request on a tick
// SHIFT  | select low, toggling SCLK and shifting the word out MSB first
// FINISH | last bit sent; raise select and pulse the matching ack
// GAP    | one tick of both selects high before the next grant
module vs_spi_arbiter
  import vs_spi_pkg::*;
#(
  parameter int CLK_DIV      = 50,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        I_CLK,
  input  logic        RST,
  input  logic        DREQ,
  input  logic        cmd_req,
  input  logic [31:0] cmd_word,
  output logic        cmd_ack,
  input  logic        data_req,
  input  logic [15:0] data_word,
  output logic        data_ack,
  output logic        SCLK,
  output logic        SI,
  output logic        XCS,
  output logic        XDCS,
  output logic        busy
);

  localparam int SW = (STARVE_LIMIT > 1) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  logic          tick;
  logic [1:0]    state;
  logic [31:0]   shreg;
  logic [5:0]    bitcnt;
  logic [SW-1:0] starve;
  logic          is_cmd;
  logic          grant_data;

  spi_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .I_CLK(I_CLK),
    .RST  (RST),
    .tick (tick)
  );

  // Command wins unless data has been passed over STARVE_LIMIT times in a row.
  assign grant_data = data_req && (!cmd_req || (starve == STARVE_MAX));
  assign SI         = shreg[31];
  assign busy       = (state != S_IDLE);

  always_ff @(posedge I_CLK) begin
    if (!RST) begin
      state    <= S_IDLE;
      shreg    <= '0;
      bitcnt   <= '0;
      starve   <= '0;
      is_cmd   <= 1'b0;
      SCLK     <= 1'b0;
      XCS      <= 1'b1;
      XDCS     <= 1'b1;
      cmd_ack  <= 1'b0;
      data_ack <= 1'b0;
    end else begin
      cmd_ack  <= 1'b0;
      data_ack <= 1'b0;
      if (tick) begin
        if (!data_req) starve <= '0;
        case (state)
          S_IDLE: begin
            if (DREQ && (cmd_req || data_req)) begin
              state <= S_SHIFT;
              if (grant_data) begin
                is_cmd <= 1'b0;
                shreg  <= {data_word, 16'h0000};
                bitcnt <= 6'(DATA_BITS);
                XDCS   <= 1'b0;
                starve <= '0;
              end else begin
                is_cmd <= 1'b1;
                shreg  <= cmd_word;
                bitcnt <= 6'(CMD_BITS);
                XCS    <= 1'b0;
                if (data_req && (starve != STARVE_MAX)) starve <= starve + 1'b1;
              end
            end
          end
          S_SHIFT: begin
            if (!SCLK) begin
              SCLK <= 1'b1;
            end else begin
              SCLK   <= 1'b0;
              bitcnt <= bitcnt - 1'b1;
              if (bitcnt == 6'd1) state <= S_FINISH;
              else                shreg <= {shreg[30:0], 1'b0};
            end
          end
          S_FINISH: begin
            XCS      <= 1'b1;
            XDCS     <= 1'b1;
            cmd_ack  <= is_cmd;
            data_ack <= !is_cmd;
            state    <= S_GAP;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_vs_spi_arbiter.sv
// Directed bench: a bus-level monitor decodes every word from SCLK/SI/selects
// and checks it against a queue of expected transfers.
module tb_vs_spi_arbiter;
  import vs_spi_pkg::*;

  localparam int CLK_DIV      = 2;
  localparam int STARVE_LIMIT = 2;
  localparam int CMD_LAT      = (1 + 64 + 1 - 1) * CLK_DIV;
  localparam int DATA_LAT     = (1 + 32 + 1 - 1) * CLK_DIV;

  logic        clk = 1'b0;
  logic        rst;
  logic        dreq;
  logic        cmd_req;
  logic [31:0] cmd_word;
  logic        cmd_ack;
  logic        data_req;
  logic [15:0] data_word;
  logic        data_ack;
  logic        sclk, si, xcs, xdcs, busy;

  always #5 clk = ~clk;

  vs_spi_arbiter #(.CLK_DIV(CLK_DIV), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .I_CLK    (clk),
    .RST      (rst),
    .DREQ     (dreq),
    .cmd_req  (cmd_req),
    .cmd_word (cmd_word),
    .cmd_ack  (cmd_ack),
    .data_req (data_req),
    .data_word(data_word),
    .data_ack (data_ack),
    .SCLK     (sclk),
    .SI       (si),
    .XCS      (xcs),
    .XDCS     (xdcs),
    .busy     (busy)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // expected transfers, in grant order (1 = command, 0 = data)
  logic        exp_kind[$];
  logic [31:0] exp_word[$];
  logic        grant_log[$];

  logic        p_sclk = 1'b0, p_si = 1'b0, p_xcs = 1'b1, p_xdcs = 1'b1;
  logic        p_cack = 1'b0, p_dack = 1'b0;
  logic [31:0] shv = '0;
  int          nbits = 0, cyc = 0, fall_cyc = 0, last_rise = 0;
  bit          rise_valid = 1'b0;
  int          n_cack = 0, n_dack = 0;
  logic [31:0] last_word = '0;
  int          last_lat = 0;

  task automatic word_done(input logic kind);
    logic        k;
    logic [31:0] w;
    check("expected_pending", 32'(exp_kind.size() != 0), 1);
    if (exp_kind.size() != 0) begin
      k = exp_kind.pop_front();
      w = exp_word.pop_front();
      check("grant_kind", 32'(kind), 32'(k));
      check("bit_count", nbits, kind ? CMD_BITS : DATA_BITS);
      last_word = kind ? shv : {16'h0, shv[15:0]};
      check("word_value", last_word, w);
      last_lat = cyc - fall_cyc;
      check("latency", last_lat, kind ? CMD_LAT : DATA_LAT);
      check("ack_with_select", {30'b0, cmd_ack, data_ack}, kind ? 2 : 1);
    end
    grant_log.push_back(kind);
    last_rise  = cyc;
    rise_valid = 1'b1;
  endtask

  always @(posedge clk) begin
    #1;
    cyc++;
    if (cmd_ack)  n_cack++;
    if (data_ack) n_dack++;
    if (!rst) begin
      nbits      = 0;
      rise_valid = 1'b0;
    end else begin
      check("select_exclusive", 32'(!xcs && !xdcs), 0);
      check("si_stable_sclk_high", 32'(sclk && (si != p_si)), 0);
      check("ack_one_cycle", 32'((cmd_ack && p_cack) || (data_ack && p_dack)), 0);
      if ((p_xcs && !xcs) || (p_xdcs && !xdcs)) begin
        nbits    = 0;
        shv      = '0;
        fall_cyc = cyc;
        check("sclk_low_at_select", 32'(sclk), 0);
        if (rise_valid) check("select_gap", 32'(cyc - last_rise >= 2 * CLK_DIV), 1);
      end
      if (!p_sclk && sclk) begin
        shv = {shv[30:0], si};
        nbits++;
      end
      if (!p_xcs && xcs)   word_done(1'b1);
      if (!p_xdcs && xdcs) word_done(1'b0);
    end
    p_sclk = sclk; p_si = si; p_xcs = xcs; p_xdcs = xdcs;
    p_cack = cmd_ack; p_dack = data_ack;
  end

  task automatic wait_acks(input string name, input int n, input int budget);
    int base = n_cack + n_dack;
    int k = 0;
    while ((n_cack + n_dack < base + n) && (k < budget)) begin
      @(posedge clk); #2;
      k++;
    end
    check(name, n_cack + n_dack - base, n);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int seen, rises, c0, d0, k;
    rst = 1'b0; dreq = 1'b0; cmd_req = 1'b0; data_req = 1'b0;
    cmd_word = '0; data_word = '0;
    repeat (3) @(negedge clk);
    @(posedge clk); #2;
    check("rst_xcs",  32'(xcs), 1);
    check("rst_xdcs", 32'(xdcs), 1);
    check("rst_sclk", 32'(sclk), 0);
    check("rst_si",   32'(si), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_acks", {30'b0, cmd_ack, data_ack}, 0);
    @(negedge clk) rst = 1'b1;

    // single command: soft reset write
    exp_kind.push_back(1'b1); exp_word.push_back(32'h02000804);
    @(negedge clk);
    dreq = 1'b1; cmd_req = 1'b1;
    cmd_word = sci_word(SCI_WRITE, REG_MODE, MODE_SOFT_RESET);
    wait_acks("cmd_ack_seen", 1, 400);
    @(negedge clk) cmd_req = 1'b0;
    check("cmd_word_literal", last_word, 32'h02000804);
    check("cmd_latency_literal", last_lat, 130);
    check("cmd_ack_count", n_cack, 1);
    check("cmd_no_data_ack", n_dack, 0);

    // single data word
    exp_kind.push_back(1'b0); exp_word.push_back(32'h0000A55A);
    data_word = 16'hA55A; data_req = 1'b1;
    wait_acks("data_ack_seen", 1, 400);
    @(negedge clk) data_req = 1'b0;
    check("data_word_literal", last_word, 32'h0000A55A);
    check("data_latency_literal", last_lat, 66);
    check("data_ack_count", n_dack, 1);

    // DREQ gating
    repeat (6) @(negedge clk);
    dreq = 1'b0; cmd_req = 1'b1;
    cmd_word = sci_word(SCI_WRITE, REG_VOL, 16'h2020);
    seen = 0;
    repeat (100 * CLK_DIV) begin
      @(posedge clk); #2;
      if (!xcs || !xdcs || busy) seen++;
    end
    check("dreq_low_idle", seen, 0);
    exp_kind.push_back(1'b1); exp_word.push_back(32'h020B2020);
    @(negedge clk) dreq = 1'b1;
    k = 0;
    while (xcs && k < 2 * CLK_DIV) begin
      @(posedge clk); #2;
      k++;
    end
    check("dreq_release_grant", 32'(!xcs), 1);
    wait_acks("gated_cmd_ack", 1, 400);
    @(negedge clk) cmd_req = 1'b0;

    // starvation bound with both requests held
    repeat (6) @(negedge clk);
    grant_log.delete();
    for (int i = 0; i < 2; i++) begin
      exp_kind.push_back(1'b1); exp_word.push_back(32'h020B2020);
      exp_kind.push_back(1'b1); exp_word.push_back(32'h020B2020);
      exp_kind.push_back(1'b0); exp_word.push_back(32'h00001234);
    end
    data_word = 16'h1234;
    cmd_req = 1'b1; data_req = 1'b1;
    wait_acks("starve_acks", 6, 6 * 400);
    @(negedge clk); cmd_req = 1'b0; data_req = 1'b0;
    check("starve_log_len", grant_log.size(), 6);
    if (grant_log.size() == 6) begin
      check("starve_order", {26'b0, grant_log[0], grant_log[1], grant_log[2],
                             grant_log[3], grant_log[4], grant_log[5]}, 32'b110110);
    end

    // reset in the middle of a command
    repeat (6) @(negedge clk);
    c0 = n_cack;
    cmd_word = 32'h02000804; cmd_req = 1'b1;
    rises = 0; k = 0;
    while (rises < 10 && k < 400) begin
      @(posedge clk); #2;
      if (sclk && dut.busy && !xcs) begin
        @(negedge clk);
        if (sclk) begin
          rises++;
          while (sclk && k < 400) begin @(negedge clk); k++; end
        end
      end
      k++;
    end
    check("rises_before_reset", rises, 10);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #2;
    check("abort_xcs",  32'(xcs), 1);
    check("abort_xdcs", 32'(xdcs), 1);
    check("abort_sclk", 32'(sclk), 0);
    check("abort_si",   32'(si), 0);
    check("abort_busy", 32'(busy), 0);
    repeat (3) @(negedge clk);
    check("abort_no_ack", n_cack, c0);
    exp_kind.push_back(1'b1); exp_word.push_back(32'h02000804);
    rst = 1'b1;
    wait_acks("post_reset_ack", 1, 400);
    @(negedge clk) cmd_req = 1'b0;
    check("post_reset_word", last_word, 32'h02000804);

    // back-to-back data words
    repeat (6) @(negedge clk);
    d0 = n_dack;
    for (int i = 0; i < 4; i++) begin
      exp_kind.push_back(1'b0); exp_word.push_back(32'(16'hC001 + i));
    end
    data_word = 16'hC001; data_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_acks("b2b_ack", 1, 400);
      @(negedge clk);
      data_word = 16'(16'hC002 + i);
      if (i == 3) data_req = 1'b0;
    end
    repeat (20) @(negedge clk);
    check("b2b_ack_count", n_dack - d0, 4);
    check("queue_drained", exp_kind.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/vs_spi_arbiter.md
Name: vs_spi_arbiter

Overview:
- Owns the single serial bus to the VS1003 decoder: SCLK, SI, XCS and XDCS.
- Arbitrates between two requesters: the SCI command requester (soft reset, volume writes; 32-bit words) and the SDI audio-data requester (16-bit ROM words).
- Generates SCLK, honours DREQ, and returns a one-cycle acknowledge per completed word.
- Lets the playback and volume controllers drop their own shifters and SCLK toggling.

Parameters:
- CLK_DIV, 50: I_CLK cycles per SCLK half-period, i.e. per tick; legal range ≥2.
- STARVE_LIMIT, 4: consecutive command grants after which a pending data request must win; legal range ≥1.

Ports:
- I_CLK  in  1  system clock
- RST  in  1  reset, synchronous, active-low
- DREQ  in  1  decoder ready; high = decoder can accept a word
- cmd_req  in  1  command transfer request (level)
- cmd_word  in  32  SCI word {op, addr, data}; MSB sent first
- cmd_ack  out  1  one I_CLK pulse when the command word is complete
- data_req  in  1  data transfer request (level)
- data_word  in  16  SDI word; MSB sent first
- data_ack  out  1  one I_CLK pulse when the data word is complete
- SCLK  out  1  serial clock, idles low
- SI  out  1  serial data
- XCS  out  1  SCI chip select, active-low
- XDCS  out  1  SDI chip select, active-low
- busy  out  1  high whenever state ≠ IDLE

Behaviour:
- Reset values (while RST=0): SCLK=0, SI=0, XCS=1, XDCS=1, cmd_ack=0, data_ack=0, busy=0, state=IDLE, tick counter=0, starve counter=0.
- Reset mid-transfer aborts immediately. Both selects rise in the same cycle. No ack is issued.
- Tick generation: counter runs 0..CLK_DIV-1 and wraps. tick=1 in the cycle where counter==CLK_DIV-1. All state changes below occur only on tick cycles; acks are the exception (see FINISH).
- IDLE, on tick:
  - Nothing happens unless DREQ=1 and at least one request is high.
  - If both requests are high: grant data when starve==STARVE_LIMIT, otherwise grant command.
  - On grant: latch the word left-aligned into a 32-bit shift register. Load the bit counter with 32 (cmd) or 16 (data). Drive XCS=0 (cmd) or XDCS=0 (data). Drive SI=word MSB. SCLK stays 0. Go to SHIFT.
  - A request deasserted before its grant tick is treated as withdrawn.
- Starve counter:
  - Increments, saturating at STARVE_LIMIT, on each command grant made while data_req=1.
  - Clears on a data grant, or on any tick where data_req=0.
- SHIFT, on tick:
  - If SCLK=0: drive SCLK=1. The decoder samples on this rising edge.
  - If SCLK=1: drive SCLK=0 and decrement the bit counter. If the counter reaches 0, go to FINISH; otherwise shift left and drive SI=next bit.
  - DREQ is ignored once a word has started.
- FINISH, on tick:
  - Deassert the active select to 1.
  - Pulse the matching ack for exactly one I_CLK cycle, the cycle after this tick.
  - Go to GAP.
- GAP, on tick: both selects held high; go to IDLE. This guarantees at least one tick of select-high between words.
- Latency, counted in ticks from the grant tick to the ack:
  - Command: 1 + 64 + 1 = 66 ticks.
  - Data: 1 + 32 + 1 = 34 ticks.
  - Next grant occurs no earlier than 2 ticks after FINISH.
- Requester rules:
  - Keep req high until ack. The word need only be stable at the grant tick.
  - A req still high at the next IDLE tick starts a new transfer.
- XCS and XDCS are never low simultaneously.
- SI changes only while SCLK=0, or at grant.

Decomposition:
- Package vs_spi_pkg holds:
  - State encoding: IDLE, SHIFT, FINISH, GAP.
  - CMD_BITS=32, DATA_BITS=16.
  - SCI constants: SCI_WRITE=8'h02, REG_MODE=8'h00, REG_VOL=8'h0B, MODE_SOFT_RESET=16'h0804.
- One sub-module: spi_tick_gen (parameter CLK_DIV; ports I_CLK, RST; output tick).

Test Plan (benches use CLK_DIV=2):
- Command transfer: DREQ=1, cmd_req=1, cmd_word=32'h02000804 -> XCS low for 66 ticks; SI sampled on 32 SCLK rises reads 02000804; cmd_ack=1 for 1 cycle; XDCS stays 1.
- Data transfer: data_req=1, data_word=16'hA55A -> XDCS low; 16 rises read A55A; data_ack pulses once; XCS stays 1.
- DREQ gating: DREQ=0 with cmd_req=1 for 100 ticks -> no select asserted, busy=0; raise DREQ -> XCS falls at the next tick.
- Priority and starvation: STARVE_LIMIT=2, both requests held high continuously, cmd_word=32'h020B2020, data_word=16'h1234 -> grant order is cmd, cmd, data, cmd, cmd, data.
- Reset mid-transfer: RST=0 after 10 SCLK rises of a command -> same cycle XCS=1, SCLK=0, SI=0, no ack. Release RST with cmd_req=1 -> a full fresh 32-bit transfer.
- Back-to-back data: data_req held high, 4 words -> each XDCS-low window is separated by ≥1 tick of XDCS=1; exactly 4 data_ack pulses.
